// File: rtl/gpio_cfg_serializer_if.sv
// Management-side bus for gpio_cfg_serializer: config
// register port, transfer handshake and serial chain pins.
interface gpio_cfg_serializer_if #(
    parameter int NPADS    = 38,
    parameter int CFG_BITS = 13
);
    localparam int AW = (NPADS > 1) ? $clog2(NPADS) : 1;

    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [CFG_BITS-1:0] cfg_wdata;
    logic [CFG_BITS-1:0] cfg_rdata;
    logic                xfer_start;
    logic                busy;
    logic                done;
    logic                serial_clock;
    logic                serial_data_out;
    logic                serial_load;
    logic                serial_resetn;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, xfer_start,
        input  cfg_rdata, busy, done,
        input  serial_clock, serial_data_out,
        input  serial_load, serial_resetn
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, xfer_start,
        output cfg_rdata, busy, done,
        output serial_clock, serial_data_out,
        output serial_load, serial_resetn
    );
endinterface

// File: rtl/gpio_cfg_serializer.sv
// Pad config chain transmitter: one word per pad, shifted out
// serially on request. GPIO_CFG_CHAIN_RESET_EN adds a chain-reset phase.
module gpio_cfg_serializer #(
    parameter int                  NPADS    = 38,
    parameter int                  CFG_BITS = 13,
    parameter int                  CLK_DIV  = 2,
    parameter logic [CFG_BITS-1:0] CFG_INIT = 13'h0403
) (
    input  logic                clock,
    input  logic                resetb,
    gpio_cfg_serializer_if.slave bus
);
    localparam int NBITS = NPADS * CFG_BITS;
    localparam int BW    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTC,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [NBITS-1:0]    shift_q, shift_d;
    logic                data_q, data_d;
    logic                rstn_q;
    logic [CFG_BITS-1:0] words_q [NPADS];
    logic [CFG_BITS-1:0] words_d [NPADS];
    logic [NBITS-1:0]    snap;
    logic                addr_ok;
    logic                wr_ok;
    logic                div_last;

    assign addr_ok  = int'(bus.cfg_addr) < NPADS;
    assign div_last = (div_q == DW'(CLK_DIV - 1));

    assign bus.cfg_rdata       = addr_ok ? words_q[bus.cfg_addr] : '0;
    assign bus.busy            = (state_q == S_RSTC)
                              || (state_q == S_SHIFT_LO)
                              || (state_q == S_SHIFT_HI)
                              || (state_q == S_LOAD);
    assign bus.done            = (state_q == S_DONE);
    assign bus.serial_clock    = (state_q == S_SHIFT_HI);
    assign bus.serial_load     = (state_q == S_LOAD);
    assign bus.serial_data_out = data_q;
    assign bus.serial_resetn   = rstn_q && (state_q != S_RSTC);

    // Next-state: word writes, snapshot on accept, bit sequencing.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        words_d = words_q;
        snap    = '0;
        wr_ok   = (state_q == S_IDLE) && bus.cfg_we && addr_ok;

        if (wr_ok) begin
            words_d[bus.cfg_addr] = bus.cfg_wdata;
        end
        // Pad NPADS-1 sits at the top so its MSB leaves first.
        for (int p = 0; p < NPADS; p++) begin
            snap[p*CFG_BITS +: CFG_BITS] = words_d[p];
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.xfer_start) begin
                    div_d = '0;
                    bit_d = '0;
`ifdef GPIO_CFG_CHAIN_RESET_EN
                    state_d = S_RSTC;
                    shift_d = snap;
`else
                    state_d = S_SHIFT_LO;
                    data_d  = snap[NBITS-1];
                    shift_d = snap << 1;
`endif
                end
            end
            S_RSTC: begin
                if (div_last) begin
                    state_d = S_SHIFT_LO;
                    div_d   = '0;
                    data_d  = shift_q[NBITS-1];
                    shift_d = shift_q << 1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_SHIFT_LO: begin
                if (div_last) begin
                    state_d = S_SHIFT_HI;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == BW'(NBITS - 1)) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_SHIFT_LO;
                        bit_d   = bit_q + BW'(1);
                        data_d  = shift_q[NBITS-1];
                        shift_d = shift_q << 1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_LOAD: begin
                if (div_last) begin
                    state_d = S_DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= 1'b0;
            rstn_q  <= 1'b0;
            for (int p = 0; p < NPADS; p++) begin
                words_q[p] <= CFG_INIT;
            end
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rstn_q  <= 1'b1;
            for (int p = 0; p < NPADS; p++) begin
                words_q[p] <= words_d[p];
            end
        end
    end
endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Scoreboard bench for gpio_cfg_serializer (NPADS=2, CLK_DIV=1)
// plus a 3-pad instance for out-of-range readback.
module tb_gpio_cfg_serializer;
`ifdef GPIO_CFG_CHAIN_RESET_EN
    localparam int OFS = 1;
    localparam logic RN1 = 1'b0;
`else
    localparam int OFS = 0;
    localparam logic RN1 = 1'b1;
`endif

    typedef struct {
        int cyc;
        int busy;
        int load_pos;
        int first_rise;
        int rises;
        int loads;
    } exp_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   exp_bits [$];
    exp_t exp_q [$];

    gpio_cfg_serializer_if #(.NPADS(2), .CFG_BITS(13)) bus ();
    gpio_cfg_serializer_if #(.NPADS(3), .CFG_BITS(13)) bus3 ();

    gpio_cfg_serializer #(
        .NPADS(2), .CFG_BITS(13), .CLK_DIV(1), .CFG_INIT(13'h0403)
    ) dut (
        .clock(clk), .resetb(resetb), .bus(bus.slave)
    );

    gpio_cfg_serializer #(
        .NPADS(3), .CFG_BITS(13), .CLK_DIV(1), .CFG_INIT(13'h0403)
    ) dut3 (
        .clock(clk), .resetb(resetb), .bus(bus3.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_xfer(input logic [12:0] w1, input logic [12:0] w0);
        exp_t e;
        for (int i = 12; i >= 0; i--) exp_bits.push_back(w1[i]);
        for (int i = 12; i >= 0; i--) exp_bits.push_back(w0[i]);
        e.cyc        = 54 + OFS;
        e.busy       = 53 + OFS;
        e.load_pos   = 53 + OFS;
        e.first_rise = 2 + OFS;
        e.rises      = 26;
        e.loads      = 1;
        exp_q.push_back(e);
    endtask

    task automatic write(input int a, input logic [12:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 1'(a);
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic readback(input string name, input int a, input int exp);
        bus.cfg_addr = 1'(a);
        #1;
        chk(name, int'(bus.cfg_rdata), exp);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    // Monitor: pops expected bits on each serial_clock rise and
    // a timing record on each done pulse.
    initial begin
        int   cyc, busy_n, loads, load_pos, first_rise, rises;
        logic prev;
        exp_t e;
        cyc = 0; busy_n = 0; loads = 0; load_pos = 0;
        first_rise = 0; rises = 0; prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                cyc = 0; busy_n = 0; loads = 0; load_pos = 0;
                first_rise = 0; rises = 0; prev = 1'b0;
            end else begin
                if (bus.busy || bus.done) cyc++;
                if (bus.busy) busy_n++;
                if (bus.busy && cyc == 1)
                    chk("resetn_first_cycle", int'(bus.serial_resetn), int'(RN1));
                if (bus.serial_load) begin
                    loads++;
                    load_pos = cyc;
                end
                if (bus.serial_clock && !prev) begin
                    rises++;
                    if (first_rise == 0) first_rise = cyc;
                    if (exp_bits.size() == 0) begin
                        chk("unexpected_rise", 1, 0);
                    end else begin
                        chk($sformatf("bit%0d", rises - 1),
                            int'(bus.serial_data_out), int'(exp_bits.pop_front()));
                    end
                end
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", cyc, e.cyc);
                        chk("busy_cycles", busy_n, e.busy);
                        chk("load_count", loads, e.loads);
                        chk("load_cycle", load_pos, e.load_pos);
                        chk("first_rise", first_rise, e.first_rise);
                        chk("rise_count", rises, e.rises);
                    end
                    cyc = 0; busy_n = 0; loads = 0; load_pos = 0;
                    first_rise = 0; rises = 0;
                end
                prev = bus.serial_clock;
            end
        end
    end

    initial begin
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_wdata = '0;
        bus.xfer_start = 1'b0;
        bus3.cfg_we = 1'b0;
        bus3.cfg_addr = '0;
        bus3.cfg_wdata = '0;
        bus3.xfer_start = 1'b0;

        ticks(3);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sclk", int'(bus.serial_clock), 0);
        chk("rst_sdo", int'(bus.serial_data_out), 0);
        chk("rst_load", int'(bus.serial_load), 0);
        chk("rst_resetn", int'(bus.serial_resetn), 0);
        resetb = 1'b1;
        tick();
        chk("rel_resetn", int'(bus.serial_resetn), 1);
        chk("rel_busy", int'(bus.busy), 0);
        readback("init_rd0", 0, 13'h0403);
        readback("init_rd1", 1, 13'h0403);
        bus3.cfg_addr = 2'd3;
        #1;
        chk("oob_rd3", int'(bus3.cfg_rdata), 0);
        bus3.cfg_addr = 2'd2;
        #1;
        chk("pad2_rd", int'(bus3.cfg_rdata), 13'h0403);

        write(1, 13'h1ABC);
        write(0, 13'h0ABC);
        readback("wr_rd1", 1, 13'h1ABC);
        readback("wr_rd0", 0, 13'h0ABC);

        // Transfer with a write and a start attempt while busy.
        push_xfer(13'h1ABC, 13'h0ABC);
        bus.xfer_start = 1'b1;
        tick();
        bus.xfer_start = 1'b0;
        ticks(4);
        write(1, 13'h0000);
        ticks(3);
        bus.xfer_start = 1'b1;
        tick();
        bus.xfer_start = 1'b0;
        wait_done();
        readback("busy_wr_ignored", 1, 13'h1ABC);

        // Back-to-back resend of unchanged words.
        tick();
        chk("done_one_cycle", int'(bus.done), 0);
        push_xfer(13'h1ABC, 13'h0ABC);
        bus.xfer_start = 1'b1;
        tick();
        bus.xfer_start = 1'b0;
        wait_done();

        // Write and start in the same cycle: new value is sent.
        tick();
        push_xfer(13'h1ABC, 13'h1555);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 1'b0;
        bus.cfg_wdata = 13'h1555;
        bus.xfer_start = 1'b1;
        tick();
        bus.cfg_we = 1'b0;
        bus.xfer_start = 1'b0;
        wait_done();
        readback("same_cycle_wr", 0, 13'h1555);

        // Abort during bit 10.
        tick();
        begin
            logic [12:0] w;
            w = 13'h1ABC;
            for (int i = 12; i >= 3; i--) exp_bits.push_back(w[i]);
        end
        bus.xfer_start = 1'b1;
        tick();
        bus.xfer_start = 1'b0;
        ticks(20 + OFS);
        chk("abort_pre_busy", int'(bus.busy), 1);
        resetb = 1'b0;
        tick();
        chk("abort_sclk", int'(bus.serial_clock), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_load", int'(bus.serial_load), 0);
        chk("abort_done", int'(bus.done), 0);
        readback("abort_rd0", 0, 13'h0403);
        readback("abort_rd1", 1, 13'h0403);
        resetb = 1'b1;
        ticks(70);
        chk("bits_left", exp_bits.size(), 0);
        chk("xfers_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
